reg_hex_ascii_streamer: RTL and testbench

Parametrised successor to the combinational nibble-to-ASCII converter. Latches a DATA_W-bit register value and streams it as 7-bit ASCII hex characters, most-significant nibble first, over a valid/ready handshake. Feeds the VGA text-overlay character writer in the RISC-V debug display path.
- Adds a latched request, optional leading-zero suppression, case selection and end-of-word marking.

---
 rtl/reg_hex_ascii_streamer_if.sv | 39 +++
 rtl/reg_hex_ascii_streamer.sv | 171 +++++++++++++++++
 tb/tb_reg_hex_ascii_streamer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_hex_ascii_streamer_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_hex_ascii_streamer_if
//  Description : Request and character-stream bundle for
//                reg_hex_ascii_streamer.
//                master = requester/consumer side, slave = streamer side.
//  Signals     : start      - request, accepted only while busy=0
//                reg_in     - DATA_W-bit value sampled at accept
//                busy       - conversion in progress
//                ascii      - 7-bit character, valid with char_valid
//                char_valid - character available
//                char_ready - consumer accepts the character
//                char_last  - final character of the word
//                done       - one-cycle pulse after the final transfer
//  Revision    : 1.0 - initial release
// ============================================================================
interface reg_hex_ascii_streamer_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [DATA_W-1:0] reg_in;
  logic              busy;
  logic [6:0]        ascii;
  logic              char_valid;
  logic              char_ready;
  logic              char_last;
  logic              done;

  modport master (
    output start, reg_in, char_ready,
    input  busy, ascii, char_valid, char_last, done
  );

  modport slave (
    input  start, reg_in, char_ready,
    output busy, ascii, char_valid, char_last, done
  );
endinterface
`default_nettype wire

// File: rtl/reg_hex_ascii_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : reg_hex_ascii_streamer
//  Description : Latches a DATA_W-bit value and streams it as 7-bit ASCII
//                hex characters, most-significant nibble first, over a
//                valid/ready handshake. Optional leading-zero suppression,
//                upper/lower case letters, last-character marking.
//  Parameters  : DATA_W        - input width, multiple of 4, >= 4
//                LOWERCASE     - 1: a-f, 0: A-F
//                ZERO_SUPPRESS - 1: skip leading zero nibbles
//  Macro       : HEX_PREFIX_EN - when defined, every word is preceded by
//                the two characters "0x".
//  Ports       : clk  - rising-edge clock
//                rst  - synchronous active-high reset
//                bus  - slave modport of reg_hex_ascii_streamer_if
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_hex_ascii_streamer #(
  parameter int DATA_W        = 32,
  parameter int LOWERCASE     = 0,
  parameter int ZERO_SUPPRESS = 0
) (
  input  wire                      clk,
  input  wire                      rst,
  reg_hex_ascii_streamer_if.slave  bus
);

  localparam int NIB   = DATA_W / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NIB - 1);
  localparam logic [IDX_W-1:0] c_IDX_ONE  = IDX_W'(1);
  localparam logic [6:0]       c_ALPHA    = (LOWERCASE != 0) ? 7'h61 : 7'h41;

`ifdef HEX_PREFIX_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_PFX  = 2'd2
  } state_t;
`else
  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;
`endif

  state_t            r_state;
  logic [DATA_W-1:0] r_val;
  logic [IDX_W-1:0]  r_idx;
  logic              r_busy;
  logic              r_valid;
  logic              r_last;
  logic              r_done;
  logic [6:0]        r_ascii;
`ifdef HEX_PREFIX_EN
  // 0: "0" is on the bus, 1: "x" is on the bus
  logic              r_pfx;
`endif

  logic [IDX_W-1:0]  w_first_idx;
  logic [IDX_W-1:0]  w_idx_dec;
  logic              w_xfer;

  function automatic logic [6:0] f_map(input logic [3:0] n);
    if (n < 4'd10) begin
      return 7'h30 + {3'b000, n};
    end
    return c_ALPHA + {3'b000, n} - 7'd10;
  endfunction

  function automatic logic [3:0] f_nib(input logic [DATA_W-1:0] v,
                                       input logic [IDX_W-1:0]  i);
    return v[{i, 2'b00} +: 4];
  endfunction

  // First nibble to emit; with suppression the highest nonzero nibble wins,
  // falling back to nibble 0 so a zero value still produces one "0".
  always_comb begin
    w_first_idx = c_LAST_IDX;
    if (ZERO_SUPPRESS != 0) begin
      w_first_idx = '0;
      for (int i = 0; i < NIB; i++) begin
        if (bus.reg_in[4*i +: 4] != 4'h0) begin
          w_first_idx = IDX_W'(i);
        end
      end
    end
  end

  assign w_idx_dec = r_idx - c_IDX_ONE;
  assign w_xfer    = r_valid & bus.char_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_val   <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
      r_ascii <= 7'h00;
`ifdef HEX_PREFIX_EN
      r_pfx   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_val   <= bus.reg_in;
            r_idx   <= w_first_idx;
            r_busy  <= 1'b1;
            r_valid <= 1'b1;
`ifdef HEX_PREFIX_EN
            r_state <= S_PFX;
            r_pfx   <= 1'b0;
            r_ascii <= 7'h30;
            r_last  <= 1'b0;
`else
            r_state <= S_EMIT;
            r_ascii <= f_map(f_nib(bus.reg_in, w_first_idx));
            r_last  <= (w_first_idx == '0);
`endif
          end
        end
`ifdef HEX_PREFIX_EN
        S_PFX: begin
          if (w_xfer) begin
            if (!r_pfx) begin
              r_pfx   <= 1'b1;
              r_ascii <= 7'h78;
            end else begin
              r_state <= S_EMIT;
              r_ascii <= f_map(f_nib(r_val, r_idx));
              r_last  <= (r_idx == '0);
            end
          end
        end
`endif
        S_EMIT: begin
          if (w_xfer) begin
            if (r_idx == '0) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
              r_ascii <= 7'h00;
            end else begin
              // Next character is registered now so it appears with no bubble
              r_idx   <= w_idx_dec;
              r_ascii <= f_map(f_nib(r_val, w_idx_dec));
              r_last  <= (r_idx == c_IDX_ONE);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.ascii      = r_ascii;
  assign bus.char_valid = r_valid;
  assign bus.char_last  = r_last;
  assign bus.done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_reg_hex_ascii_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_hex_ascii_streamer
//  Description : Self-checking bench. Instance A: upper case, no suppression.
//                Instance B: lower case with leading-zero suppression.
//                A queue-based model of the character string is compared
//                against both instances every cycle; the transferred
//                characters are also checked against hand-written strings.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_hex_ascii_streamer;

  typedef logic [6:0] str_t [0:9];

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  bit   started  = 1'b0;

  always #5 clk = ~clk;

  reg_hex_ascii_streamer_if #(.DATA_W(32)) bus_a ();
  reg_hex_ascii_streamer_if #(.DATA_W(32)) bus_b ();

  reg_hex_ascii_streamer #(.DATA_W(32), .LOWERCASE(0), .ZERO_SUPPRESS(0))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  reg_hex_ascii_streamer #(.DATA_W(32), .LOWERCASE(1), .ZERO_SUPPRESS(1))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  // ---------------- model: expected character string per instance --------
  logic [6:0] q_a[$];
  logic [6:0] q_b[$];
  bit         done_a = 1'b0;
  bit         done_b = 1'b0;
  logic [6:0] log_a[$];
  logic [6:0] log_b[$];

  function automatic int build(input logic [31:0] v, input bit lc,
                               input bit zs, output str_t s);
    int top;
    int k;
    int n;
    for (int i = 0; i < 10; i++) s[i] = 7'h00;
    top = 7;
    k   = 0;
    if (zs) begin
      top = 0;
      for (int i = 0; i < 8; i++)
        if (((v >> (4*i)) & 32'hF) != 0) top = i;
    end
`ifdef HEX_PREFIX_EN
    s[0] = 7'h30;
    s[1] = 7'h78;
    k    = 2;
`endif
    for (int i = top; i >= 0; i--) begin
      n = int'((v >> (4*i)) & 32'hF);
      if (n < 10) s[k] = 7'(48 + n);
      else        s[k] = 7'((lc ? 97 : 65) + n - 10);
      k++;
    end
    return k;
  endfunction

  always @(posedge clk) begin
    str_t s;
    int   n;
    started = 1'b1;
    if (rst) begin
      q_a.delete(); q_b.delete();
      done_a = 1'b0; done_b = 1'b0;
    end else begin
      done_a = 1'b0;
      if (q_a.size() != 0) begin
        if (bus_a.char_ready) begin
          void'(q_a.pop_front());
          if (q_a.size() == 0) done_a = 1'b1;
        end
      end else if (bus_a.start) begin
        n = build(bus_a.reg_in, 1'b0, 1'b0, s);
        for (int i = 0; i < n; i++) q_a.push_back(s[i]);
      end
      done_b = 1'b0;
      if (q_b.size() != 0) begin
        if (bus_b.char_ready) begin
          void'(q_b.pop_front());
          if (q_b.size() == 0) done_b = 1'b1;
        end
      end else if (bus_b.start) begin
        n = build(bus_b.reg_in, 1'b1, 1'b1, s);
        for (int i = 0; i < n; i++) q_b.push_back(s[i]);
      end
    end
  end

  // ---------------- per-cycle compare, away from the active edge ----------
  always @(negedge clk) begin
    logic [10:0] got;
    logic [10:0] exp;
    if (started) begin
      got = {bus_a.busy, bus_a.char_valid, bus_a.char_last, bus_a.done,
             bus_a.char_valid ? bus_a.ascii : 7'h00};
      exp = {q_a.size() != 0, q_a.size() != 0, q_a.size() == 1, done_a,
             (q_a.size() != 0) ? q_a[0] : 7'h00};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL cycle_a t=%0t got busy/valid/last/done/ascii=%b required=%b",
                 $time, got, exp);
      end
      got = {bus_b.busy, bus_b.char_valid, bus_b.char_last, bus_b.done,
             bus_b.char_valid ? bus_b.ascii : 7'h00};
      exp = {q_b.size() != 0, q_b.size() != 0, q_b.size() == 1, done_b,
             (q_b.size() != 0) ? q_b[0] : 7'h00};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL cycle_b t=%0t got busy/valid/last/done/ascii=%b required=%b",
                 $time, got, exp);
      end
      if (bus_a.char_valid && bus_a.char_ready) log_a.push_back(bus_a.ascii);
      if (bus_b.char_valid && bus_b.char_ready) log_b.push_back(bus_b.ascii);
    end
  end

  // ---------------- helpers -----------------------------------------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pops one word from the chosen transfer log and compares it with a
  // hand-written character string (prefix added when that build is active).
  task automatic check_seq(input string name, input bit which,
                           input logic [6:0] word[$]);
    logic [6:0] exp[$];
    logic [6:0] got[$];
    exp = {};
`ifdef HEX_PREFIX_EN
    exp.push_back(7'h30);
    exp.push_back(7'h78);
`endif
    foreach (word[i]) exp.push_back(word[i]);
    got = {};
    for (int i = 0; i < exp.size(); i++) begin
      if (which == 1'b0 && log_a.size() != 0) got.push_back(log_a.pop_front());
      if (which == 1'b1 && log_b.size() != 0) got.push_back(log_b.pop_front());
    end
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%p required=%p", name, got, exp);
    end
  endtask

  task automatic check_lit(input string name, input logic [10:0] got,
                           input logic [10:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b required=%b", name, got, exp);
    end
  endtask

  // ---------------- directed stimulus -------------------------------------
  initial begin
    logic [6:0] w[$];
    bit         seen;
    bus_a.start = 1'b0; bus_a.reg_in = '0; bus_a.char_ready = 1'b1;
    bus_b.start = 1'b0; bus_b.reg_in = '0; bus_b.char_ready = 1'b1;
    rst = 1'b1;
    tick(2);
    check_lit("reset_a",
              {bus_a.busy, bus_a.char_valid, bus_a.char_last, bus_a.done, bus_a.ascii},
              11'h000);
    check_lit("reset_b",
              {bus_b.busy, bus_b.char_valid, bus_b.char_last, bus_b.done, bus_b.ascii},
              11'h000);
    rst = 1'b0;
    tick();

    // Plain word at full throughput
    bus_a.reg_in = 32'h1234ABCD; bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    check_lit("busy_after_accept", {10'h0, bus_a.busy}, 11'h001);
    tick(14);
    w = '{7'h31, 7'h32, 7'h33, 7'h34, 7'h41, 7'h42, 7'h43, 7'h44};
    check_seq("word_1234ABCD", 1'b0, w);

    // Lower case with suppression, then the all-zero word
    bus_b.reg_in = 32'h000000EF; bus_b.start = 1'b1;
    tick();
    bus_b.start = 1'b0;
    tick(6);
    w = '{7'h65, 7'h66};
    check_seq("word_EF_lc_zs", 1'b1, w);
    bus_b.reg_in = 32'h0; bus_b.start = 1'b1;
    tick();
    bus_b.start = 1'b0;
    tick(6);
    w = '{7'h30};
    check_seq("word_zero_zs", 1'b1, w);
    bus_b.reg_in = 32'h0000000A; bus_b.start = 1'b1;
    tick();
    bus_b.start = 1'b0;
    tick(6);
    w = '{7'h61};
    check_seq("word_A_zs", 1'b1, w);

    // Backpressure: ready pattern 1,0,0 repeating
    bus_a.reg_in = 32'hDEADBEEF; bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    for (int i = 0; i < 33; i++) begin
      bus_a.char_ready = (i % 3 == 0);
      tick();
    end
    bus_a.char_ready = 1'b1;
    tick(6);
    w = '{7'h44, 7'h45, 7'h41, 7'h44, 7'h42, 7'h45, 7'h45, 7'h46};
    check_seq("word_DEADBEEF_bp", 1'b0, w);

    // start while busy is ignored; start in the done cycle is accepted
    bus_a.reg_in = 32'h1234ABCD; bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    tick(3);
    bus_a.reg_in = 32'hFFFFFFFF; bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus_a.done) seen = 1'b1;
      else tick();
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL done_wait got no done pulse required one within 20 cycles");
    end
    bus_a.reg_in = 32'h000000A5; bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    check_lit("busy_after_done_accept", {10'h0, bus_a.busy}, 11'h001);
    tick(14);
    w = '{7'h31, 7'h32, 7'h33, 7'h34, 7'h41, 7'h42, 7'h43, 7'h44};
    check_seq("word_ignore_busy_start", 1'b0, w);
    w = '{7'h30, 7'h30, 7'h30, 7'h30, 7'h30, 7'h30, 7'h41, 7'h35};
    check_seq("word_done_cycle_start", 1'b0, w);

    // Reset after the third transfer aborts without a done pulse
    bus_a.reg_in = 32'h1234ABCD; bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    tick(3);
    rst = 1'b1;
    tick();
    check_lit("abort_reset",
              {8'h0, bus_a.busy, bus_a.char_valid, bus_a.done}, 11'h000);
    rst = 1'b0;
    log_a.delete();
    tick();
    bus_a.reg_in = 32'h00000001; bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    tick(14);
    w = '{7'h30, 7'h30, 7'h30, 7'h30, 7'h30, 7'h30, 7'h30, 7'h31};
    check_seq("word_00000001", 1'b0, w);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
